// File: rtl/uart_tx_frame_sequencer_if.sv
// uart_tx_frame_sequencer_if: host-side write/busy/done handshake of the UART transmit sequencer
interface uart_tx_frame_sequencer_if #(parameter int DATA_BITS = 8);
  logic Tx_WR;
  logic [DATA_BITS-1:0] Tx_DATA;
  logic Tx_BUSY;
  logic Tx_DONE;
  modport master(output Tx_WR, Tx_DATA, input Tx_BUSY, Tx_DONE);
  modport slave(input Tx_WR, Tx_DATA, output Tx_BUSY, Tx_DONE);
endinterface

// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer: serialises start/data/parity/stop bits on TxD, paced by oversample ticks
module uart_tx_frame_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic Tx_sample_ENABLE,
  uart_tx_frame_sequencer_if.slave host,
  output logic TxD,
  output logic [3:0] bits,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_cnt
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS + PARITY_EN + STOP_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_BITS-1:0] shift;
  logic par;
  logic busy;
  logic done;
  logic bit_end;
  assign bit_end = Tx_sample_ENABLE && sample_cnt == SW'(OVERSAMPLE - 1);
  assign host.Tx_BUSY = busy;
  assign host.Tx_DONE = done;
  // frame FSM: accept a word in IDLE, then step one bit per OVERSAMPLE counted ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      TxD <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      bits <= '0;
      sample_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (host.Tx_WR) begin
          shift <= host.Tx_DATA;
          par <= ^host.Tx_DATA ^ 1'(PARITY_ODD);
          state <= START;
          TxD <= 1'b0;
          busy <= 1'b1;
        end
      end else if (Tx_sample_ENABLE) begin
        if (!bit_end) sample_cnt <= sample_cnt + 1'b1;
        else begin
          sample_cnt <= '0;
          bits <= bits + 4'd1;
          case (state)
            START: begin
              state <= DATA;
              TxD <= shift[0];
            end
            DATA: begin
              shift <= shift >> 1;
              TxD <= bits == LAST_DATA ? (PARITY_EN != 0 ? par : 1'b1) : shift[1];
              state <= bits == LAST_DATA ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            end
            PARITY: begin
              state <= STOP;
              TxD <= 1'b1;
            end
            STOP: begin
              if (bits == LAST_BIT) begin
                state <= IDLE;
                bits <= '0;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// tb_uart_tx_frame_sequencer: directed checks of 8N1, 8E1, 8O1 and 7N2 sequencers
module tb_uart_tx_frame_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [3:0] wr = 4'b0;
  logic [7:0] data = 8'h00;
  wire [3:0] txd;
  wire [3:0] busy;
  wire [3:0] done;
  wire [3:0] bits [4];
  wire [3:0] sc [4];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tc = 0;
  int div = 1;
  int last_done = 0;
  int t0 = 0;
  always #5 clk = ~clk;
  uart_tx_frame_sequencer_if #(.DATA_BITS(8)) h0 ();
  uart_tx_frame_sequencer_if #(.DATA_BITS(8)) h1 ();
  uart_tx_frame_sequencer_if #(.DATA_BITS(8)) h2 ();
  uart_tx_frame_sequencer_if #(.DATA_BITS(7)) h3 ();
  assign h0.Tx_WR = wr[0];
  assign h1.Tx_WR = wr[1];
  assign h2.Tx_WR = wr[2];
  assign h3.Tx_WR = wr[3];
  assign h0.Tx_DATA = data;
  assign h1.Tx_DATA = data;
  assign h2.Tx_DATA = data;
  assign h3.Tx_DATA = data[6:0];
  assign busy = {h3.Tx_BUSY, h2.Tx_BUSY, h1.Tx_BUSY, h0.Tx_BUSY};
  assign done = {h3.Tx_DONE, h2.Tx_DONE, h1.Tx_DONE, h0.Tx_DONE};
  uart_tx_frame_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .Tx_sample_ENABLE(tick), .host(h0), .TxD(txd[0]), .bits(bits[0]), .sample_cnt(sc[0]));
  uart_tx_frame_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .Tx_sample_ENABLE(tick), .host(h1), .TxD(txd[1]), .bits(bits[1]), .sample_cnt(sc[1]));
  uart_tx_frame_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .Tx_sample_ENABLE(tick), .host(h2), .TxD(txd[2]), .bits(bits[2]), .sample_cnt(sc[2]));
  uart_tx_frame_sequencer #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .Tx_sample_ENABLE(tick), .host(h3), .TxD(txd[3]), .bits(bits[3]), .sample_cnt(sc[3]));
  // observed {TxD, Tx_BUSY, Tx_DONE, bits, sample_cnt} of sequencer d
  function automatic logic [10:0] obs(input int d);
    return {txd[d], busy[d], done[d], bits[d], sc[d]};
  endfunction
  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    tc = (tc + 1 >= div) ? 0 : tc + 1;
    tick = (tc == 0);
  endtask
  // raise Tx_WR together with a tick, which must not be counted
  task automatic launch(input int d, input logic [7:0] v);
    wr[d] = 1'b1;
    data = v;
    tc = 0;
    tick = 1'b1;
  endtask
  // walk one frame clock by clock; pat bit i is the expected TxD level during bit i
  task automatic frame(input int d, input logic [12:0] pat, input int f, input int inj, input int abort,
                       input int nd, input logic [7:0] nv);
    int p;
    int e;
    p = 16 * div;
    for (int j = 1; j <= f * p + 1; j++) begin
      step();
      if (j == 1 || j == inj + 2) wr[d] = 1'b0;
      e = j - 1;
      if (e < f * p) chk("frame", obs(d), {pat[e/p], 1'b1, 1'b0, 4'(e / p), 4'((e % p) / div)});
      else begin
        chk("done", obs(d), {1'b1, 1'b0, 1'b1, 4'd0, 4'd0});
        last_done = cyc;
      end
      if (e == inj) begin
        wr[d] = 1'b1;
        data = 8'hFF;
      end
      if (e == abort) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort", obs(d), 11'b1_0_0_0000_0000);
        step();
        chk("abort_idle", obs(d), 11'b1_0_0_0000_0000);
        return;
      end
    end
    if (nd >= 0) launch(nd, nv);
    else begin
      step();
      chk("idle", obs(d), 11'b1_0_0_0000_0000);
    end
  endtask
  initial begin
    repeat (3) step();
    for (int d = 0; d < 4; d++) chk("reset", obs(d), 11'b1_0_0_0000_0000);
    reset = 1'b0;
    repeat (3) step();
    chk("idle_tick", obs(0), 11'b1_0_0_0000_0000);
    launch(0, 8'hA5);
    frame(0, 13'b0_0011_0100_1010, 10, -1, -1, -1, 8'h00);
    launch(1, 8'h03);
    frame(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, -1, -1, 8'h00);
    launch(2, 8'h03);
    frame(2, {1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, -1, -1, 8'h00);
    launch(1, 8'h07);
    frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, -1, -1, 8'h00);
    div = 3;
    launch(0, 8'h00);
    frame(0, {1'b1, 8'h00, 1'b0}, 10, -1, -1, -1, 8'h00);
    div = 1;
    launch(0, 8'h11);
    frame(0, {1'b1, 8'h11, 1'b0}, 10, 69, -1, -1, 8'h00);
    step();
    chk("no_queue", obs(0), 11'b1_0_0_0000_0000);
    launch(0, 8'h3C);
    frame(0, {1'b1, 8'h3C, 1'b0}, 10, -1, 87, -1, 8'h00);
    launch(0, 8'h5A);
    frame(0, {1'b1, 8'h5A, 1'b0}, 10, -1, -1, -1, 8'h00);
    launch(3, 8'h55);
    frame(3, {2'b11, 7'h55, 1'b0}, 10, -1, -1, 3, 8'h2A);
    t0 = last_done;
    frame(3, {2'b11, 7'h2A, 1'b0}, 10, -1, -1, -1, 8'h00);
    tests++;
    assert (last_done - t0 === 161) else begin
      fails++;
      $error("FAIL done_gap got=%0d exp=161", last_done - t0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
